// File: rtl/efuse_wb_pkg.sv
// Shared state encoding, bit-index width and popcount helper for the eFuse Wishbone sequencer.
package efuse_wb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_SENSE,
      ST_PG_SETUP,
      ST_PG_PULSE,
      ST_PG_GAP,
      ST_ACK
   } state_t;

   localparam int BIT_IDX_W = 3;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/efuse_bit_pick.sv
// Lowest-set-bit picker over an 8-bit program mask; purely combinational, zero latency.
module efuse_bit_pick
   import efuse_wb_pkg::*;
(
   input  logic [7:0]           i_mask,
   output logic [BIT_IDX_W-1:0] o_idx,
   output logic                 o_vld
);

   always_comb begin
      o_idx = '0;
      o_vld = 1'b0;
      // Scan from the top so the lowest set bit is the last one written.
      for (int i = 7; i >= 0; i--) begin
         if (i_mask[i]) begin
            o_idx = BIT_IDX_W'(i);
            o_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/efuse_wb_sequencer.sv
// Wishbone classic responder that senses or programs a 64x8 eFuse macro one bit at a time.
// Read ack after RD_CYCLES+1 cycles, write ack after n*(PGM_CYCLES+2)+1; bus held until ack.
module efuse_wb_sequencer
   import efuse_wb_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 8,
   parameter int RD_CYCLES  = 4,
   parameter int PGM_CYCLES = 200
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_ni,
   input  logic                 wbs_cyc_i,
   input  logic                 wbs_stb_i,
   input  logic                 wbs_we_i,
   input  logic [3:0]           wbs_sel_i,
   input  logic [31:0]          wbs_adr_i,
   input  logic [31:0]          wbs_dat_i,
   output logic                 wbs_ack_o,
   output logic [31:0]          wbs_dat_o,
   output logic [ADDR_W-1:0]    efuse_addr_o,
   output logic [BIT_IDX_W-1:0] efuse_bit_o,
   output logic                 efuse_sense_o,
   output logic                 efuse_pgm_en_o,
   output logic                 efuse_pgm_o,
   input  logic [DATA_W-1:0]    efuse_dout_i
);

   localparam int CNT_MAX = (RD_CYCLES > PGM_CYCLES) ? RD_CYCLES : PGM_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES);
   localparam logic [CNT_W-1:0] PG_LOAD = CNT_W'(PGM_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [7:0]           r_mask;
   logic [BIT_IDX_W-1:0] r_bit;
   logic [ADDR_W-1:0]    r_addr;
   logic                 r_abort;
   logic                 r_ack;
   logic [31:0]          r_dat;
   logic                 r_sense;
   logic                 r_pgm_en;
   logic                 r_pgm;

   logic                 w_req;
   logic [7:0]           w_mask_clr;
   logic [7:0]           w_pick_in;
   logic [BIT_IDX_W-1:0] w_pick_idx;
   logic                 w_pick_vld;
   logic                 w_unused;

   assign w_req      = wbs_cyc_i & wbs_stb_i & ~r_ack;
   assign w_mask_clr = r_mask & ~(8'b1 << r_bit);
   // In IDLE the first bit is picked straight from the bus so PG_SETUP follows accept directly.
   assign w_pick_in  = (r_state == ST_IDLE) ? wbs_dat_i[7:0] : w_mask_clr;
   assign w_unused   = ^{wbs_sel_i[3:1], wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0], wbs_dat_i[31:8]};

   efuse_bit_pick u_pick (
      .i_mask (w_pick_in),
      .o_idx  (w_pick_idx),
      .o_vld  (w_pick_vld)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_mask   <= '0;
         r_bit    <= '0;
         r_addr   <= '0;
         r_abort  <= 1'b0;
         r_ack    <= 1'b0;
         r_dat    <= '0;
         r_sense  <= 1'b0;
         r_pgm_en <= 1'b0;
         r_pgm    <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         r_dat <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_addr  <= wbs_adr_i[ADDR_W+1:2];
                  r_mask  <= wbs_dat_i[7:0];
                  r_abort <= 1'b0;
                  if (!wbs_we_i) begin
                     r_state <= ST_RD_SENSE;
                     r_sense <= 1'b1;
                     r_cnt   <= RD_LOAD;
                  end else if (wbs_sel_i[0] && w_pick_vld) begin
                     r_state  <= ST_PG_SETUP;
                     r_pgm_en <= 1'b1;
                     r_bit    <= w_pick_idx;
                  end else begin
                     r_state <= ST_ACK;
                     r_ack   <= 1'b1;
                  end
               end
            end
            ST_RD_SENSE: begin
               if (!wbs_cyc_i) begin
                  r_state <= ST_IDLE;
                  r_sense <= 1'b0;
               end else if (r_cnt == CNT_ONE) begin
                  r_state <= ST_ACK;
                  r_sense <= 1'b0;
                  r_ack   <= 1'b1;
                  r_dat   <= {{(32-DATA_W){1'b0}}, efuse_dout_i};
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            ST_PG_SETUP: begin
               if (!wbs_cyc_i) begin
                  r_state  <= ST_IDLE;
                  r_pgm_en <= 1'b0;
               end else begin
                  r_state <= ST_PG_PULSE;
                  r_pgm   <= 1'b1;
                  r_cnt   <= PG_LOAD;
               end
            end
            ST_PG_PULSE: begin
               // A started pulse always runs to full width; an abort only takes effect at its end.
               if (r_cnt == CNT_ONE) begin
                  r_pgm <= 1'b0;
                  if (r_abort || !wbs_cyc_i) begin
                     r_state  <= ST_IDLE;
                     r_pgm_en <= 1'b0;
                  end else begin
                     r_state <= ST_PG_GAP;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
                  if (!wbs_cyc_i) begin
                     r_abort <= 1'b1;
                  end
               end
            end
            ST_PG_GAP: begin
               r_mask <= w_mask_clr;
               if (!wbs_cyc_i) begin
                  r_state  <= ST_IDLE;
                  r_pgm_en <= 1'b0;
               end else if (w_pick_vld) begin
                  r_state <= ST_PG_SETUP;
                  r_bit   <= w_pick_idx;
               end else begin
                  r_state  <= ST_ACK;
                  r_pgm_en <= 1'b0;
                  r_ack    <= 1'b1;
               end
            end
            ST_ACK: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign wbs_ack_o      = r_ack;
   assign wbs_dat_o      = r_dat;
   assign efuse_addr_o   = r_addr;
   assign efuse_bit_o    = r_bit;
   assign efuse_sense_o  = r_sense;
   assign efuse_pgm_en_o = r_pgm_en;
   assign efuse_pgm_o    = r_pgm;

   a_pulse_bit_set: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
      (r_state == ST_PG_PULSE) |-> r_mask[r_bit]);
   a_setup_has_work: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_ni)
      (r_state == ST_PG_SETUP) |-> (popcount8(r_mask) != 4'd0));

endmodule

// File: tb/tb_efuse_wb_sequencer.sv
// Randomized bench for efuse_wb_sequencer with a fuse-array model and a request-level reference.
module tb_efuse_wb_sequencer;
   import efuse_wb_pkg::*;

   localparam int ADDR_W     = 6;
   localparam int DATA_W     = 8;
   localparam int RD_CYCLES  = 4;
   localparam int PGM_CYCLES = 200;

   logic        wb_clk_i  = 1'b0;
   logic        wb_rst_ni = 1'b1;
   logic        wbs_cyc_i = 1'b0;
   logic        wbs_stb_i = 1'b0;
   logic        wbs_we_i  = 1'b0;
   logic [3:0]  wbs_sel_i = 4'h0;
   logic [31:0] wbs_adr_i = 32'h0;
   logic [31:0] wbs_dat_i = 32'h0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [ADDR_W-1:0] efuse_addr_o;
   logic [2:0]  efuse_bit_o;
   logic        efuse_sense_o;
   logic        efuse_pgm_en_o;
   logic        efuse_pgm_o;
   logic [DATA_W-1:0] efuse_dout_i;

   typedef struct { int bit_i; int addr; int len; } pulse_t;

   logic [7:0] fuse_mem [64];
   logic [7:0] ref_mem  [64];

   int checks = 0;
   int errors = 0;
   int cyc_no = 0;

   int ack_cnt, ack_cyc, sense_cnt, sense_addr, en_cyc, en_rises;
   logic [31:0] ack_dat;
   int ack_multi = 0, dat_leak = 0, sig_unstable = 0, pgm_no_en = 0;
   bit prev_ack = 0, prev_pgm = 0, prev_en = 0;
   pulse_t cur;
   pulse_t pq[$];

   always #5 wb_clk_i = ~wb_clk_i;

   assign efuse_dout_i = efuse_sense_o ? fuse_mem[efuse_addr_o] : 8'h3C;

   efuse_wb_sequencer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_CYCLES(RD_CYCLES), .PGM_CYCLES(PGM_CYCLES)
   ) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .efuse_addr_o(efuse_addr_o), .efuse_bit_o(efuse_bit_o),
      .efuse_sense_o(efuse_sense_o), .efuse_pgm_en_o(efuse_pgm_en_o),
      .efuse_pgm_o(efuse_pgm_o), .efuse_dout_i(efuse_dout_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pin monitor: samples 1 time unit after each rising edge; full-width pulses blow the fuse.
   initial begin
      forever begin
         @(posedge wb_clk_i);
         cyc_no++;
         #1;
         if (!wb_rst_ni) begin
            prev_ack = 0;
            prev_pgm = 0;
            prev_en  = 0;
         end else begin
            if (wbs_ack_o) begin
               ack_cnt++;
               ack_cyc = cyc_no;
               ack_dat = wbs_dat_o;
               if (prev_ack) ack_multi++;
            end else if (wbs_dat_o != 32'h0) begin
               dat_leak++;
            end
            if (efuse_sense_o) begin
               if (sense_cnt == 0) sense_addr = int'(efuse_addr_o);
               else if (int'(efuse_addr_o) != sense_addr) sig_unstable++;
               sense_cnt++;
            end
            if (efuse_pgm_en_o) begin
               en_cyc++;
               if (!prev_en) en_rises++;
            end
            if (efuse_pgm_o) begin
               if (!efuse_pgm_en_o) pgm_no_en++;
               if (!prev_pgm) begin
                  cur.bit_i = int'(efuse_bit_o);
                  cur.addr  = int'(efuse_addr_o);
                  cur.len   = 0;
               end else if (cur.bit_i != int'(efuse_bit_o) || cur.addr != int'(efuse_addr_o)) begin
                  sig_unstable++;
               end
               cur.len++;
            end else if (prev_pgm) begin
               pq.push_back(cur);
               if (cur.len == PGM_CYCLES) fuse_mem[cur.addr][cur.bit_i] = 1'b1;
            end
            prev_ack = wbs_ack_o;
            prev_pgm = efuse_pgm_o;
            prev_en  = efuse_pgm_en_o;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired at cycle %0d", cyc_no);
      $fatal(1, "watchdog");
   end

   task automatic clear_mon();
      ack_cnt = 0; sense_cnt = 0; en_cyc = 0; en_rises = 0; ack_dat = 32'h0;
      pq.delete();
   endtask

   // Issue one request at a falling edge; acc_delay=1 when the slave is still in its ack cycle.
   task automatic do_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit hold, input int acc_delay);
      int acc, a, n, idx;
      logic [7:0] m;
      bit eff;
      clear_mon();
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
      acc = cyc_no + acc_delay;
      a   = int'(adr[7:2]);
      m   = dat[7:0];
      eff = we && sel[0];
      n   = eff ? int'(popcount8(m)) : 0;
      for (int i = 0; i < 4000 && ack_cnt == 0; i++) @(negedge wb_clk_i);
      check("ack_seen", 32'(ack_cnt > 0), 32'd1);
      if (!hold) begin
         wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      end
      if (!we) begin
         check("rd_lat", 32'(ack_cyc - acc), 32'(RD_CYCLES + 1));
         check("rd_dat", ack_dat, {24'h0, ref_mem[a]});
         check("rd_sense_len", 32'(sense_cnt), 32'(RD_CYCLES));
         check("rd_sense_addr", 32'(sense_addr), 32'(a));
         check("rd_no_pgm_en", 32'(en_cyc), 32'd0);
      end else begin
         check("wr_lat", 32'(ack_cyc - acc), 32'(n * (PGM_CYCLES + 2) + 1));
         check("wr_npulse", 32'(pq.size()), 32'(n));
         idx = 0;
         for (int b = 0; b < 8; b++) begin
            if (eff && m[b]) begin
               if (idx < pq.size()) begin
                  check("wr_bit", 32'(pq[idx].bit_i), 32'(b));
                  check("wr_addr", 32'(pq[idx].addr), 32'(a));
                  check("wr_len", 32'(pq[idx].len), 32'(PGM_CYCLES));
               end
               idx++;
            end
         end
         check("wr_en_cyc", 32'(en_cyc), 32'(n * (PGM_CYCLES + 2)));
         check("wr_en_rise", 32'(en_rises), (n > 0) ? 32'd1 : 32'd0);
         check("wr_no_sense", 32'(sense_cnt), 32'd0);
         check("wr_ack_dat", ack_dat, 32'h0);
         if (eff) ref_mem[a] = ref_mem[a] | m;
      end
      if (!hold) @(negedge wb_clk_i);
   endtask

   task automatic do_abort(input logic [31:0] adr);
      int a;
      clear_mon();
      a = int'(adr[7:2]);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_adr_i = adr;  wbs_dat_i = 32'h03; wbs_sel_i = 4'h1;
      for (int i = 0; i < 10 && !efuse_pgm_o; i++) @(negedge wb_clk_i);
      check("ab_pulse_start", 32'(efuse_pgm_o), 32'd1);
      repeat (50) @(negedge wb_clk_i);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      repeat (PGM_CYCLES + 20) @(negedge wb_clk_i);
      check("ab_npulse", 32'(pq.size()), 32'd1);
      if (pq.size() > 0) begin
         check("ab_bit", 32'(pq[0].bit_i), 32'd0);
         check("ab_len", 32'(pq[0].len), 32'(PGM_CYCLES));
      end
      check("ab_no_ack", 32'(ack_cnt), 32'd0);
      check("ab_en_low", 32'(efuse_pgm_en_o), 32'd0);
      ref_mem[a] = ref_mem[a] | 8'h01;
   endtask

   task automatic do_reset_mid_pulse();
      logic [7:0] m;
      clear_mon();
      m = 8'($urandom) | 8'h10;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_adr_i = 32'h0; wbs_dat_i = {24'h0, m}; wbs_sel_i = 4'h1;
      for (int i = 0; i < 10 && !efuse_pgm_o; i++) @(negedge wb_clk_i);
      check("rst_pulse_start", 32'(efuse_pgm_o), 32'd1);
      repeat ($urandom_range(1, 150)) @(negedge wb_clk_i);
      #1;
      wb_rst_ni = 1'b0;
      #1;
      check("rst_pgm_async", 32'(efuse_pgm_o), 32'd0);
      check("rst_en_async", 32'(efuse_pgm_en_o), 32'd0);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      @(negedge wb_clk_i);
      check("rst_mid_ctl", 32'({wbs_ack_o, efuse_addr_o, efuse_bit_o, efuse_sense_o,
                                efuse_pgm_en_o, efuse_pgm_o}), 32'd0);
      wb_rst_ni = 1'b1;
      @(negedge wb_clk_i);
   endtask

   initial begin
      logic [31:0] adr, dat;
      logic [3:0]  sel;
      for (int i = 0; i < 64; i++) begin
         fuse_mem[i] = 8'($urandom);
         ref_mem[i]  = fuse_mem[i];
      end
      fuse_mem[3] = 8'hA5;
      ref_mem[3]  = 8'hA5;
      #1 wb_rst_ni = 1'b0;
      repeat (3) @(negedge wb_clk_i);
      check("reset_dat", wbs_dat_o, 32'h0);
      check("reset_ctl", 32'({wbs_ack_o, efuse_addr_o, efuse_bit_o, efuse_sense_o,
                              efuse_pgm_en_o, efuse_pgm_o}), 32'd0);
      wb_rst_ni = 1'b1;
      @(negedge wb_clk_i);

      do_txn(1'b0, 32'h0000_000C, 32'h0, 4'hF, 1'b0, 0);
      do_txn(1'b1, 32'h0000_0004, 32'h81, 4'h1, 1'b0, 0);
      do_txn(1'b0, 32'h0000_0004, 32'h0, 4'h1, 1'b0, 0);
      do_txn(1'b1, 32'h0000_0010, 32'h00, 4'hF, 1'b0, 0);
      do_txn(1'b1, 32'h0000_0014, 32'hFF, 4'h0, 1'b0, 0);
      do_txn(1'b0, 32'h0000_0014, 32'h0, 4'h1, 1'b0, 0);

      adr = {$urandom, 2'b00};
      do_abort(adr);
      do_txn(1'b0, adr, 32'h0, 4'h1, 1'b0, 0);

      do_reset_mid_pulse();
      do_txn(1'b0, 32'h0000_0000, 32'h0, 4'h1, 1'b0, 0);

      // Back-to-back with stb held across the first ack.
      do_txn(1'b0, 32'hFFFF_FF08, 32'h0, 4'h1, 1'b1, 0);
      do_txn(1'b1, 32'h0000_0018, 32'h22, 4'h1, 1'b0, 1);

      for (int t = 0; t < 20; t++) begin
         adr = $urandom;
         adr[7:2] = 6'($urandom_range(0, 7));
         dat = $urandom;
         if ($urandom_range(0, 3) == 0) dat[7:0] = 8'h00;
         sel = 4'($urandom);
         if ($urandom_range(0, 4) != 0) sel[0] = 1'b1;
         do_txn(1'($urandom), adr, dat, sel, 1'b0, 0);
      end
      for (int i = 0; i < 8; i++) begin
         do_txn(1'b0, 32'(i * 4), 32'h0, 4'h1, 1'b0, 0);
      end

      check("ack_single_cycle", 32'(ack_multi), 32'd0);
      check("dat_zero_no_ack", 32'(dat_leak), 32'd0);
      check("pins_stable", 32'(sig_unstable), 32'd0);
      check("pgm_inside_en", 32'(pgm_no_en), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
